herculesae_vx_aesimc_iter: RTL and testbench



---
 rtl/herculesae_vx_aesimc_iter.sv | 144 ++++++++++++++
 tb/tb_herculesae_vx_aesimc_iter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/herculesae_vx_aesimc_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : herculesae_vx_aesimc_iter                                     |
// | Purpose  : Iterative AES InverseMixColumns. Takes one 128-bit state over  |
// |            a valid/ready handshake and runs one 32-bit column per cycle  |
// |            through a single shared GF(2^8) column engine. The 128-bit    |
// |            result is returned over a second valid/ready handshake.       |
// | Ports    : clk       - rising-edge clock                                 |
// |            reset     - asynchronous active-high reset                    |
// |            in_valid  - d_in carries a state to process                   |
// |            in_ready  - block accepts d_in this cycle                     |
// |            d_in      - state; column c at [32c+31:32c], row r byte at    |
// |                        [32c+8r+7:32c+8r]                                 |
// |            out_valid - d_out holds a completed result                    |
// |            out_ready - consumer accepts d_out                            |
// |            d_out     - InverseMixColumns(d_in), same byte packing        |
// | Config   : HERCULESAE_AESIMC_ZEROIZE_EN - clears the data registers once |
// |            they are no longer needed and masks d_out while not valid     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module herculesae_vx_aesimc_iter (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] d_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] d_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         state_q;
  logic [1:0]     col_q;
  logic [127:0]   src_q;
  logic [127:0]   res_q;
  logic           out_valid_q;

  logic [31:0]    col_src;
  logic [31:0]    col_res;

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // One InverseMixColumns column; the 09/0b/0d/0e multiples share the
  // x2/x4/x8 chain of each input byte.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
    logic [7:0] b   [4];
    logic [7:0] m9  [4];
    logic [7:0] mb  [4];
    logic [7:0] md  [4];
    logic [7:0] me  [4];
    logic [7:0] x2, x4, x8;
    for (int r = 0; r < 4; r++) begin
      b[r]  = a[8*r +: 8];
      x2    = xtime(b[r]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[r] = x8 ^ b[r];
      mb[r] = x8 ^ x2 ^ b[r];
      md[r] = x8 ^ x4 ^ b[r];
      me[r] = x8 ^ x4 ^ x2;
    end
    inv_mix_col[7:0]   = me[0] ^ mb[1] ^ md[2] ^ m9[3];
    inv_mix_col[15:8]  = m9[0] ^ me[1] ^ mb[2] ^ md[3];
    inv_mix_col[23:16] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
    inv_mix_col[31:24] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
  endfunction

  assign col_src = src_q[{col_q, 5'b0} +: 32];
  assign col_res = inv_mix_col(col_src);

  // A new block can enter from IDLE, or from DONE in the same cycle the
  // current result is taken.
  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign out_valid = out_valid_q;

`ifdef HERCULESAE_AESIMC_ZEROIZE_EN
  assign d_out = out_valid_q ? res_q : 128'h0;
`else
  assign d_out = res_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      col_q       <= 2'd0;
      src_q       <= 128'h0;
      res_q       <= 128'h0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            src_q   <= d_in;
            col_q   <= 2'd0;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          res_q[{col_q, 5'b0} +: 32] <= col_res;
          col_q <= col_q + 2'd1;
          if (col_q == 2'd3) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
`ifdef HERCULESAE_AESIMC_ZEROIZE_EN
            src_q       <= 128'h0;
`endif
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              src_q   <= d_in;
              col_q   <= 2'd0;
              state_q <= ST_BUSY;
            end else begin
              state_q <= ST_IDLE;
`ifdef HERCULESAE_AESIMC_ZEROIZE_EN
              src_q   <= 128'h0;
              res_q   <= 128'h0;
`endif
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          col_q       <= 2'd0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_herculesae_vx_aesimc_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_herculesae_vx_aesimc_iter                                  |
// | Purpose  : Directed self-checking bench for the iterative AES             |
// |            InverseMixColumns unit, using known AES column vectors.       |
// | Config   : HERCULESAE_AESIMC_ZEROIZE_EN selects the zeroizing            |
// |            expectations after an output handshake                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_herculesae_vx_aesimc_iter;

  logic         clk       = 1'b0;
  logic         reset     = 1'b1;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] d_in      = 128'h0;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] d_out;

  int tests = 0;
  int fails = 0;

  // Known column pairs: InverseMixColumns(col_in[k]) = col_out[k].
  logic [31:0] col_in  [6];
  logic [31:0] col_out [6];

  herculesae_vx_aesimc_iter dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d_in      (d_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d_out     (d_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present d and wait for the input handshake, then count edges until
  // out_valid is seen. Returns 1 cycle after an edge, in DONE.
  task automatic push(input logic [127:0] d, input logic keep, output int lat);
    int n;
    in_valid = 1'b1;
    d_in     = d;
    n        = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    if (!keep) in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int           lat;
    logic [127:0] blk, exp, held;
    int           k;

    col_in[0] = 32'hbca14d8e; col_out[0] = 32'h455313db;
    col_in[1] = 32'h9d58dc9f; col_out[1] = 32'h5c220af2;
    col_in[2] = 32'h01010101; col_out[2] = 32'h01010101;
    col_in[3] = 32'hc6c6c6c6; col_out[3] = 32'hc6c6c6c6;
    col_in[4] = 32'hd6d7d5d5; col_out[4] = 32'hd5d4d4d4;
    col_in[5] = 32'hf8bd7e4d; col_out[5] = 32'h4c31262d;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_in_ready",  128'(in_ready),  128'd1);
    chk("rst_d_out",     d_out,           128'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single column block, latency check
    push({96'h0, 32'hbca14d8e}, 1'b0, lat);
    chk("blk1_latency", 128'(lat), 128'd4);
    chk("blk1_d_out", d_out, {96'h0, 32'h455313db});
    held = d_out;

    // Backpressure: DONE held for 6 cycles
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_d_out",     d_out,           held);
      chk("bp_in_ready",  128'(in_ready),  128'd0);
    end

    // Release with a new input in the same cycle
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 128'(in_ready), 128'd1);
    push({32'hd6d7d5d5, 32'hc6c6c6c6, 32'h01010101, 32'h9d58dc9f}, 1'b0, lat);
    chk("blk2_latency", 128'(lat), 128'd4);
    chk("blk2_d_out", d_out, {32'hd5d4d4d4, 32'hc6c6c6c6, 32'h01010101, 32'h5c220af2});

    // Stream 8 blocks, in_valid and out_ready held high
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < 4; c++) begin
        k = (i + 2 * c + (i / 6)) % 6;
        blk[32*c +: 32] = col_in[k];
        exp[32*c +: 32] = col_out[k];
      end
      push(blk, 1'b1, lat);
      chk($sformatf("stream%0d_latency", i), 128'(lat), 128'd4);
      chk($sformatf("stream%0d_d_out", i), d_out, exp);
    end
    held = d_out;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain_out_valid", 128'(out_valid), 128'd0);
    chk("drain_in_ready",  128'(in_ready),  128'd1);
`ifdef HERCULESAE_AESIMC_ZEROIZE_EN
    chk("zeroize_d_out", d_out,     128'h0);
    chk("zeroize_src",   dut.src_q, 128'h0);
    chk("zeroize_res",   dut.res_q, 128'h0);
`else
    chk("retain_d_out", d_out, held);
`endif

    // Reset while BUSY at col=2
    in_valid = 1'b1;
    d_in     = {32'hf8bd7e4d, 32'hd6d7d5d5, 32'h9d58dc9f, 32'hbca14d8e};
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("pre_rst_out_valid", 128'(out_valid), 128'd0);
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'd0);
    chk("midrst_in_ready",  128'(in_ready),  128'd1);
    chk("midrst_d_out",     d_out,           128'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    push({32'hd6d7d5d5, 32'h01010101, 32'hf8bd7e4d, 32'h9d58dc9f}, 1'b0, lat);
    chk("post_rst_latency", 128'(lat), 128'd4);
    chk("post_rst_d_out", d_out, {32'hd5d4d4d4, 32'h01010101, 32'h4c31262d, 32'h5c220af2});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
